// File: rtl/pipeline2_pkg.sv
// Shared constants for the pipeline2 arithmetic pipeline.
package pipeline2_pkg;

    // Default operand width
    localparam int unsigned N_DEFAULT = 10;

    // Per-transaction operation select for the stage-2 combine step
    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/pipeline2_pipe_slice.sv
// Valid/ready register slice: one pipeline stage holding a W-bit payload.
// The payload is only loaded on a real transfer, so a bubble keeps the old data.
module pipe_slice #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Stage can take new contents when empty or when its contents leave this edge
    assign in_ready = !out_valid || out_ready;

    // Stage register: valid bit follows upstream whenever enabled, data only on a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/pipeline2.sv
// Three-stage valid/ready pipeline computing F = ((A+B) op (C-D)) * D.
// op is add or subtract, chosen per transaction by mode, and travels with the data.
module pipeline2
    import pipeline2_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned OUT_W = 2 * N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic [N-1:0]     C,
    input  logic [N-1:0]     D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] F,
    output logic             busy
);

    // Stage payloads: {mode, D, x1, x2}, {x3, D}, product
    localparam int unsigned S1_W = 3 * N + 1;
    localparam int unsigned S2_W = 2 * N;

    logic [N-1:0]     x1_in;
    logic [N-1:0]     x2_in;
    logic [S1_W-1:0]  s1_in;
    logic [S1_W-1:0]  s1_q;
    logic             v1;
    logic             r2;

    logic             mode1_q;
    logic [N-1:0]     d1_q;
    logic [N-1:0]     x1_q;
    logic [N-1:0]     x2_q;
    logic [N-1:0]     x3;
    logic [S2_W-1:0]  s2_in;
    logic [S2_W-1:0]  s2_q;
    logic             v2;
    logic             r3;

    logic [N-1:0]     x3_q;
    logic [N-1:0]     d2_q;
    logic [OUT_W-1:0] prod;

    // Stage-1 arithmetic: both sums wrap modulo 2^N
    always_comb begin
        x1_in = A + B;
        x2_in = C - D;
    end

    assign s1_in = {mode, D, x1_in, x2_in};

    pipe_slice #(.W(S1_W)) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (v1),
        .out_ready (r2),
        .out_data  (s1_q)
    );

    assign {mode1_q, d1_q, x1_q, x2_q} = s1_q;

    // Stage-2 arithmetic: combine x1 and x2 according to the carried mode
    always_comb begin
        x3 = x1_q + x2_q;
        if (mode_e'(mode1_q) == MODE_SUB) begin
            x3 = x1_q - x2_q;
        end
    end

    assign s2_in = {x3, d1_q};

    pipe_slice #(.W(S2_W)) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .in_ready  (r2),
        .in_data   (s2_in),
        .out_valid (v2),
        .out_ready (r3),
        .out_data  (s2_q)
    );

    assign {x3_q, d2_q} = s2_q;

    // Stage-3 arithmetic: full-precision unsigned product, no truncation
    always_comb begin
        prod = OUT_W'(x3_q) * OUT_W'(d2_q);
    end

    pipe_slice #(.W(OUT_W)) u_s3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v2),
        .in_ready  (r3),
        .in_data   (prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (F)
    );

    assign busy = v1 | v2 | out_valid;

endmodule

// File: tb/tb_pipeline2.sv
// Self-checking bench for pipeline2: directed literal cases plus randomized
// traffic, all checked against a transaction-level queue model.
module tb_pipeline2;

    localparam int NW = 10;
    localparam int OW = 2 * NW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          mode;
    logic [NW-1:0] A;
    logic [NW-1:0] B;
    logic [NW-1:0] C;
    logic [NW-1:0] D;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] F;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int exp_q[$];
    int acc_q[$];
    bit hold_chk = 0;
    int hold_f   = 0;

    pipeline2 #(.N(NW), .OUT_W(OW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .F         (F),
        .busy      (busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result straight from the arithmetic definition
    function automatic int model_f(input bit m, input int a, input int b, input int c, input int d);
        int msk;
        int s;
        int t;
        int x;
        msk = (1 << NW) - 1;
        s = (a + b) & msk;
        t = (c - d) & msk;
        x = m ? ((s - t) & msk) : ((s + t) & msk);
        return x * d;
    endfunction

    function automatic int rnd_op();
        int k;
        k = $urandom_range(0, 7);
        if (k == 0) return 0;
        if (k == 1) return (1 << NW) - 1;
        return $urandom_range(0, (1 << NW) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_txn(input bit v, input bit m, input int a, input int b, input int c, input int d);
        in_valid = v;
        mode     = m;
        A        = a[NW-1:0];
        B        = b[NW-1:0];
        C        = c[NW-1:0];
        D        = d[NW-1:0];
    endtask

    // Compare process: sampled mid-cycle, checks the DUT against the queue model
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            hold_chk = 0;
        end else begin
            cyc++;
            check("busy", busy, exp_q.size() != 0);
            check("in_ready", in_ready, (exp_q.size() < 3) || out_ready);
            if (hold_chk) begin
                check("stall_valid", out_valid, 1);
                check("stall_f", F, hold_f);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", out_valid, 0);
                end else begin
                    check("f", F, exp_q[0]);
                    check("latency_min", (cyc - acc_q[0]) >= 3, 1);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            hold_chk = out_valid && !out_ready;
            hold_f   = int'(F);
            if (in_valid && in_ready) begin
                exp_q.push_back(model_f(mode, int'(A), int'(B), int'(C), int'(D)));
                acc_q.push_back(cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pending;
        rst_n     = 0;
        out_ready = 1;
        set_txn(0, 0, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_f", F, 0);
        check("rst_busy", busy, 0);
        rst_n = 1;
        #1;
        check("rst_in_ready", in_ready, 1);
        tick();

        // Basic: 3+4=7, 9-5=4, 11*5=55, three register stages
        check("basic_ready", in_ready, 1);
        set_txn(1, 0, 3, 4, 9, 5);
        tick();
        set_txn(0, 0, 0, 0, 0, 0);
        check("basic_lat1", out_valid, 0);
        tick();
        check("basic_lat2", out_valid, 0);
        tick();
        check("basic_valid", out_valid, 1);
        check("basic_f", F, 55);
        tick();
        check("basic_empty", out_valid, 0);
        check("basic_busy", busy, 0);

        // Mode select back-to-back: 55 then (7-4)*5=15
        set_txn(1, 0, 3, 4, 9, 5);
        tick();
        set_txn(1, 1, 3, 4, 9, 5);
        tick();
        set_txn(0, 0, 0, 0, 0, 0);
        tick();
        check("mode_f0", F, 55);
        tick();
        check("mode_v1", out_valid, 1);
        check("mode_f1", F, 15);
        tick();
        check("mode_end", out_valid, 0);

        // Wrap-around and full-width product
        set_txn(1, 0, 1023, 1, 0, 1);
        tick();
        set_txn(1, 0, 1000, 0, 1023, 1023);
        tick();
        set_txn(0, 0, 0, 0, 0, 0);
        tick();
        check("wrap_f0", F, 1023);
        tick();
        check("wrap_f1", F, 1023000);
        tick();

        // Back-pressure: fill three stages, fourth must wait
        out_ready = 0;
        set_txn(1, 0, 3, 4, 9, 5);
        tick();
        set_txn(1, 1, 3, 4, 9, 5);
        tick();
        set_txn(1, 0, 1, 1, 1, 1);
        tick();
        set_txn(1, 1, 2, 2, 3, 2);
        #1;
        check("bp_full_ready", in_ready, 0);
        check("bp_head_f", F, 55);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_f", F, 55);
            check("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        set_txn(0, 0, 0, 0, 0, 0);
        check("bp_busy", busy, 1);
        check("bp_f1", F, 15);
        tick();
        check("bp_f2", F, 2);
        tick();
        check("bp_f3", F, 6);
        tick();
        check("bp_end", out_valid, 0);

        // Bubbles: in_valid 1,0,1,0 gives out_valid 1,0,1,0 three edges later
        set_txn(1, 0, 1, 1, 1, 1);
        tick();
        set_txn(0, 0, 0, 0, 0, 0);
        tick();
        set_txn(1, 1, 2, 2, 3, 2);
        tick();
        set_txn(0, 0, 0, 0, 0, 0);
        check("bub_v0", out_valid, 1);
        check("bub_f0", F, 2);
        tick();
        check("bub_v1", out_valid, 0);
        tick();
        check("bub_v2", out_valid, 1);
        check("bub_f2", F, 6);
        tick();
        check("bub_v3", out_valid, 0);

        // Asynchronous reset with two transactions in flight
        set_txn(1, 0, 3, 4, 9, 5);
        tick();
        set_txn(1, 1, 3, 4, 9, 5);
        tick();
        set_txn(0, 0, 0, 0, 0, 0);
        check("ar_busy_before", busy, 1);
        #2;
        rst_n = 0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_f", F, 0);
        check("ar_busy", busy, 0);
        repeat (2) @(posedge clk);
        #4;
        rst_n = 1;
        tick();
        check("ar_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            check("ar_no_stale", out_valid, 0);
            tick();
        end
        set_txn(1, 0, 1000, 0, 1023, 1023);
        tick();
        set_txn(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("ar_fresh_v", out_valid, 1);
        check("ar_fresh_f", F, 1023000);
        tick();

        // Randomized traffic, producer holds inputs while stalled
        pending = 0;
        for (int i = 0; i < 600; i++) begin
            if (!pending) begin
                set_txn($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        rnd_op(), rnd_op(), rnd_op(), rnd_op());
            end
            if (i >= 200 && i < 300) out_ready = ($urandom_range(0, 4) == 0);
            else                     out_ready = ($urandom_range(0, 3) != 0);
            #1;
            pending = in_valid && !in_ready;
            @(posedge clk);
            #1;
        end

        // Drain and confirm nothing is lost
        set_txn(0, 0, 0, 0, 0, 0);
        out_ready = 1;
        repeat (6) tick();
        check("drain_busy", busy, 0);
        check("drain_outstanding", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
